pippo_div_ctrl: RTL and testbench
=================================

Name: pippo_div_ctrl

Overview:
- Sequencing controller for the 64/32 pipelined non-restoring divider in the pippo execution unit.
- Accepts one 32-bit signed or unsigned divide request at a time, converts operands to magnitudes, and drives the divider datapath with a gated enable for the fixed pipeline depth.
- Applies sign correction to the quotient and remainder, and resolves divide-by-zero and signed overflow without using the divider.
- Returns the result through a valid/ready response port and supports a kill (flush) from the pipeline.

Parameters:
- D_WIDTH, 32, operand / quotient / remainder width; divider dividend width is 2*D_WIDTH.
- DIV_LAT, D_WIDTH+1, number of div_ena cycles from operand launch to a stable quotient/remainder at the divider outputs.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  divide request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_signed  input  1  1 = signed divide, 0 = unsigned
- req_a  input  D_WIDTH  dividend
- req_b  input  D_WIDTH  divisor
- req_kill  input  1  flush the current operation; no response is produced
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_q  output  D_WIDTH  quotient
- rsp_r  output  D_WIDTH  remainder
- rsp_div0  output  1  divisor was zero
- rsp_ovf  output  1  signed overflow (most-negative / -1)
- div_ena  output  1  divider pipeline enable
- div_z  output  2*D_WIDTH  divider dividend, {D_WIDTH zeros, |a|}
- div_d  output  D_WIDTH  divider divisor, |b|
- div_q  input  D_WIDTH  divider quotient
- div_s  input  D_WIDTH  divider remainder

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=0, operand registers=0, req_ready=1, rsp_valid=0, div_ena=0, rsp_* data=0, flags=0.
- Acceptance occurs on a rising edge where req_valid & req_ready & !req_kill.
- At acceptance, register |a| and |b|. Magnitude is two's-complement negate when req_signed is 1 and the MSB is set; otherwise the raw value.
- At acceptance, also register neg_q = signed & (a[MSB]^b[MSB]) & (b!=0) and neg_r = signed & a[MSB].
- div_z and div_d are driven from the operand registers and stay stable from acceptance until return to IDLE.
- States:
  - IDLE: req_ready=1. On acceptance with b==0, or signed with a==100..0 and b==all ones: latch the special result and go to DONE; div_ena is never asserted. Otherwise cnt<=0 and go to RUN.
  - RUN: div_ena=1 and cnt increments each cycle. The cycle with cnt==DIV_LAT-1 is the last enabled cycle; next state is DONE.
  - DONE: div_ena=0, so the divider holds q/s. rsp_valid=1. On rsp_valid & rsp_ready, go to IDLE.
- Latency: request accepted at edge E0. RUN spans the DIV_LAT cycles after E0. rsp_valid first rises in cycle E0+DIV_LAT+1 (34 cycles at defaults). Special cases give rsp_valid in cycle E0+1.
- Result in normal case: rsp_q = neg_q ? -div_q : div_q; rsp_r = neg_r ? -div_s : div_s; rsp_div0=0, rsp_ovf=0. Data is combinational from the held divider outputs while in DONE.
- Divide by zero: rsp_q = all ones, rsp_r = a (original, unsigned form), rsp_div0=1.
- Signed overflow: rsp_q = 100..0, rsp_r = 0, rsp_ovf=1.
- Divider div0/ovf outputs are not used; the controller resolves both conditions itself.
- rsp_* data is stable while rsp_valid=1 and rsp_ready=0; the hold is unbounded.
- req_ready=0 in RUN and DONE. Requests presented there are not accepted and must be held by the requester.
- req_kill:
  - In RUN or DONE: next state IDLE, div_ena=0 from the next cycle, no rsp_valid for the killed op. Divider pipeline contents are don't-care, since the next op restarts the full DIV_LAT count.
  - In IDLE: suppresses acceptance in that cycle.
  - In DONE coinciding with rsp_ready: kill wins and the response is treated as not delivered.
- Back-to-back: a new request may be accepted in the first IDLE cycle after the DONE handshake. There is no IDLE bypass.
- rst asserted mid-RUN forces IDLE immediately and deasserts div_ena asynchronously.

Test Plan:
- Unsigned 100 / 7 -> rsp_valid 34 cycles after acceptance; q=14, r=2; div_ena high for exactly 33 cycles.
- Signed -100 / 7 -> q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2). Signed 100 / -7 -> q=-14, r=2. Unsigned 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
- Divide by zero, a=0x1234, signed and unsigned -> rsp_valid next cycle; q=0xFFFFFFFF, r=0x1234, rsp_div0=1; div_ena never asserted.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, rsp_ovf=1, 1-cycle latency. The same operands unsigned -> q=0, r=0x80000000 via the full 34-cycle path.
- rsp_ready held low 10 cycles in DONE -> rsp_* stable, req_ready=0. Then release -> IDLE. Next request accepted and produces the correct independent result.
- req_kill at RUN cycle 15 -> IDLE next cycle, no rsp_valid. An immediately following 81/9 request -> q=9, r=0 after a full 34 cycles. rst pulsed mid-RUN -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/pippo_div_ctrl.sv
// Sequencing controller for the pippo 64/32 pipelined divider: operand magnitude conversion,
// gated pipeline enable, sign correction, and local resolution of divide-by-zero and overflow.
module pippo_div_ctrl #(
    parameter int unsigned D_WIDTH = 32,
    parameter int unsigned DIV_LAT = D_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_signed,
    input  logic [D_WIDTH-1:0]   req_a,
    input  logic [D_WIDTH-1:0]   req_b,
    input  logic                 req_kill,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [D_WIDTH-1:0]   rsp_q,
    output logic [D_WIDTH-1:0]   rsp_r,
    output logic                 rsp_div0,
    output logic                 rsp_ovf,
    output logic                 div_ena,
    output logic [2*D_WIDTH-1:0] div_z,
    output logic [D_WIDTH-1:0]   div_d,
    input  logic [D_WIDTH-1:0]   div_q,
    input  logic [D_WIDTH-1:0]   div_s
);

    localparam int unsigned CntW = $clog2(DIV_LAT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_LAT - 1);
    localparam logic [D_WIDTH-1:0] MostNeg = {1'b1, {(D_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic [D_WIDTH-1:0]  a_mag_q, b_mag_q;
    logic                neg_q_q, neg_r_q;
    logic                special_q, div0_q, ovf_q;
    logic [D_WIDTH-1:0]  spec_q_q, spec_r_q;

    logic                accept;
    logic                a_neg, b_neg;
    logic                is_div0, is_ovf, is_special;
    logic [D_WIDTH-1:0]  a_mag, b_mag;

    assign accept     = req_valid && (state_q == StIdle) && !req_kill;
    assign a_neg      = req_signed && req_a[D_WIDTH-1];
    assign b_neg      = req_signed && req_b[D_WIDTH-1];
    assign a_mag      = a_neg ? -req_a : req_a;
    assign b_mag      = b_neg ? -req_b : req_b;
    assign is_div0    = (req_b == '0);
    assign is_ovf     = req_signed && (req_a == MostNeg) && (req_b == '1);
    assign is_special = is_div0 || is_ovf;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill overrides both completion and delivery
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = is_special ? StDone : StRun;
                end
            end
            StRun: begin
                if (req_kill) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (req_kill || rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Operand, counter and special-result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            special_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            spec_q_q  <= '0;
            spec_r_q  <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            a_mag_q   <= a_mag;
            b_mag_q   <= b_mag;
            neg_q_q   <= req_signed && (req_a[D_WIDTH-1] ^ req_b[D_WIDTH-1]) && !is_div0;
            neg_r_q   <= a_neg;
            special_q <= is_special;
            div0_q    <= is_div0;
            ovf_q     <= is_ovf && !is_div0;
            spec_q_q  <= is_div0 ? '1 : MostNeg;
            spec_r_q  <= is_div0 ? req_a : '0;
        end else if (state_q == StRun) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign div_z = {{D_WIDTH{1'b0}}, a_mag_q};
    assign div_d = b_mag_q;

    // Outputs; response data is only driven while a result is presented
    always_comb begin
        req_ready = 1'b0;
        div_ena   = 1'b0;
        rsp_valid = 1'b0;
        rsp_q     = '0;
        rsp_r     = '0;
        rsp_div0  = 1'b0;
        rsp_ovf   = 1'b0;
        unique case (state_q)
            StIdle: req_ready = 1'b1;
            StRun:  div_ena   = 1'b1;
            StDone: begin
                rsp_valid = 1'b1;
                if (special_q) begin
                    rsp_q    = spec_q_q;
                    rsp_r    = spec_r_q;
                    rsp_div0 = div0_q;
                    rsp_ovf  = ovf_q;
                end else begin
                    rsp_q = neg_q_q ? -div_q : div_q;
                    rsp_r = neg_r_q ? -div_s : div_s;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pippo_div_ctrl.sv
// Directed self-checking bench for pippo_div_ctrl with a behavioural divider that only
// presents a valid quotient after the full enabled pipeline depth.
module tb_pippo_div_ctrl;

    localparam int DW  = 32;
    localparam int LAT = 33;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready, req_signed, req_kill;
    logic [DW-1:0] req_a, req_b;
    logic          rsp_valid, rsp_ready, rsp_div0, rsp_ovf;
    logic [DW-1:0] rsp_q, rsp_r;
    logic          div_ena;
    logic [2*DW-1:0] div_z;
    logic [DW-1:0] div_d, div_q, div_s;

    int passed;
    int total;
    int ena_cnt;

    pippo_div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_kill   (req_kill),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_r      (rsp_r),
        .rsp_div0   (rsp_div0),
        .rsp_ovf    (rsp_ovf),
        .div_ena    (div_ena),
        .div_z      (div_z),
        .div_d      (div_d),
        .div_q      (div_q),
        .div_s      (div_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: results are garbage until LAT enabled cycles have elapsed
    always @(posedge clk or posedge rst) begin
        if (rst || req_ready) ena_cnt <= 0;
        else if (div_ena) ena_cnt <= ena_cnt + 1;
    end

    always_comb begin
        div_q = 32'hDEAD_BEEF;
        div_s = 32'hBAD0_BAD0;
        if (ena_cnt >= LAT && div_d != 0) begin
            div_q = div_z[DW-1:0] / div_d;
            div_s = div_z[DW-1:0] % div_d;
        end
    end

    // Launch one request and wait for its response; lat counts cycles from acceptance
    task automatic start_op(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            output int lat, output int ena,
                            output logic [DW-1:0] q, output logic [DW-1:0] r,
                            output logic d0, output logic ov,
                            output logic [2*DW-1:0] z, output logic [DW-1:0] d);
        req_valid  = 1'b1;
        req_signed = s;
        req_a      = a;
        req_b      = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        z   = div_z;
        d   = div_d;
        lat = 1;
        ena = 0;
        while (!rsp_valid && lat < 200) begin
            if (div_ena) ena++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = 999;
        q  = rsp_q;
        r  = rsp_r;
        d0 = rsp_div0;
        ov = rsp_ovf;
    endtask

    task automatic finish_op();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else passed++;
        total++; if (div_ena !== 1'b0) $display("FAIL reset_div_ena got %b exp 0", div_ena); else passed++;
        total++; if ({rsp_q, rsp_r, rsp_div0, rsp_ovf} !== '0)
            $display("FAIL reset_rsp_data got %h %h %b %b exp 0", rsp_q, rsp_r, rsp_div0, rsp_ovf);
        else passed++;
        total++; if (div_z !== 64'h0 || div_d !== 32'h0)
            $display("FAIL reset_operands got %h %h exp 0", div_z, div_d);
        else passed++;
    endtask

    task automatic test_normal();
        logic          vs[6];
        logic [DW-1:0] va[6], vb[6], eq[6], er[6], ez[6], ed[6];
        int lat, ena;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        vs[0] = 0; va[0] = 32'd100;      vb[0] = 32'd7;          eq[0] = 32'd14;       er[0] = 32'd2;
        vs[1] = 1; va[1] = 32'hFFFFFF9C; vb[1] = 32'd7;          eq[1] = 32'hFFFFFFF2; er[1] = 32'hFFFFFFFE;
        vs[2] = 1; va[2] = 32'd100;      vb[2] = 32'hFFFFFFF9;   eq[2] = 32'hFFFFFFF2; er[2] = 32'd2;
        vs[3] = 0; va[3] = 32'hFFFFFFFF; vb[3] = 32'd1;          eq[3] = 32'hFFFFFFFF; er[3] = 32'd0;
        vs[4] = 1; va[4] = 32'hFFFFFF9C; vb[4] = 32'hFFFFFFF9;   eq[4] = 32'd14;       er[4] = 32'hFFFFFFFE;
        vs[5] = 0; va[5] = 32'h80000000; vb[5] = 32'hFFFFFFFF;   eq[5] = 32'd0;        er[5] = 32'h80000000;
        ez[0] = 32'd100; ez[1] = 32'd100; ez[2] = 32'd100; ez[3] = 32'hFFFFFFFF; ez[4] = 32'd100;
        ez[5] = 32'h80000000;
        ed[0] = 32'd7; ed[1] = 32'd7; ed[2] = 32'd7; ed[3] = 32'd1; ed[4] = 32'd7; ed[5] = 32'hFFFFFFFF;
        for (int i = 0; i < 6; i++) begin
            start_op(vs[i], va[i], vb[i], lat, ena, q, r, d0, ov, z, d);
            total++; if (lat !== 34) $display("FAIL normal%0d_latency got %0d exp 34", i, lat); else passed++;
            total++; if (ena !== 33) $display("FAIL normal%0d_ena_cycles got %0d exp 33", i, ena); else passed++;
            total++; if (q !== eq[i]) $display("FAIL normal%0d_q got %h exp %h", i, q, eq[i]); else passed++;
            total++; if (r !== er[i]) $display("FAIL normal%0d_r got %h exp %h", i, r, er[i]); else passed++;
            total++; if (d0 !== 1'b0 || ov !== 1'b0)
                $display("FAIL normal%0d_flags got %b%b exp 00", i, d0, ov);
            else passed++;
            total++; if (z !== {32'h0, ez[i]} || d !== ed[i])
                $display("FAIL normal%0d_operands got %h %h exp %h %h", i, z, d, ez[i], ed[i]);
            else passed++;
            finish_op();
            total++; if (req_ready !== 1'b1) $display("FAIL normal%0d_idle got %b exp 1", i, req_ready); else passed++;
        end
    endtask

    task automatic test_div0();
        logic          vs[3];
        logic [DW-1:0] va[3];
        int lat, ena;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        vs[0] = 0; va[0] = 32'h1234;
        vs[1] = 1; va[1] = 32'h1234;
        vs[2] = 1; va[2] = 32'h80000005;
        for (int i = 0; i < 3; i++) begin
            start_op(vs[i], va[i], 32'h0, lat, ena, q, r, d0, ov, z, d);
            total++; if (lat !== 1) $display("FAIL div0_%0d_latency got %0d exp 1", i, lat); else passed++;
            total++; if (ena !== 0 || div_ena !== 1'b0)
                $display("FAIL div0_%0d_ena got %0d exp 0", i, ena);
            else passed++;
            total++; if (q !== 32'hFFFFFFFF) $display("FAIL div0_%0d_q got %h exp ffffffff", i, q); else passed++;
            total++; if (r !== va[i]) $display("FAIL div0_%0d_r got %h exp %h", i, r, va[i]); else passed++;
            total++; if (d0 !== 1'b1 || ov !== 1'b0) $display("FAIL div0_%0d_flags got %b%b exp 10", i, d0, ov); else passed++;
            finish_op();
        end
    endtask

    task automatic test_ovf();
        int lat, ena;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, ena, q, r, d0, ov, z, d);
        total++; if (lat !== 1 || ena !== 0) $display("FAIL ovf_latency got %0d/%0d exp 1/0", lat, ena); else passed++;
        total++; if (q !== 32'h80000000) $display("FAIL ovf_q got %h exp 80000000", q); else passed++;
        total++; if (r !== 32'h0) $display("FAIL ovf_r got %h exp 0", r); else passed++;
        total++; if (ov !== 1'b1 || d0 !== 1'b0) $display("FAIL ovf_flags got %b%b exp 01", d0, ov); else passed++;
        finish_op();
    endtask

    task automatic test_hold();
        int lat, ena, bad;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        start_op(1'b0, 32'd1000, 32'd33, lat, ena, q, r, d0, ov, z, d);
        total++; if (q !== 32'd30 || r !== 32'd10) $display("FAIL hold_result got %0d %0d exp 30 10", q, r); else passed++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_a = 32'd5;
            req_b = 32'd5;
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || rsp_q !== 32'd30 || rsp_r !== 32'd10 || req_ready !== 1'b0) bad++;
        end
        req_valid = 1'b0;
        total++; if (bad !== 0) $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); else passed++;
        finish_op();
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL hold_release got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
        else passed++;
        // Back-to-back: accepted in the first IDLE cycle after the handshake
        start_op(1'b1, 32'hFFFFFFF6, 32'd3, lat, ena, q, r, d0, ov, z, d);
        total++; if (lat !== 34) $display("FAIL b2b_latency got %0d exp 34", lat); else passed++;
        total++; if (q !== 32'hFFFFFFFD || r !== 32'hFFFFFFFF)
            $display("FAIL b2b_result got %h %h exp fffffffd ffffffff", q, r);
        else passed++;
        finish_op();
    endtask

    task automatic test_kill_idle();
        req_valid = 1'b1;
        req_kill  = 1'b1;
        req_a = 32'd10;
        req_b = 32'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_kill  = 1'b0;
        total++; if (req_ready !== 1'b1 || div_ena !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL kill_idle got ready=%b ena=%b valid=%b exp 1 0 0", req_ready, div_ena, rsp_valid);
        else passed++;
    endtask

    task automatic test_kill();
        int lat, ena, seen;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        req_valid  = 1'b1;
        req_signed = 1'b0;
        req_a = 32'd1000;
        req_b = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        total++; if (div_ena !== 1'b1) $display("FAIL kill_run15 got ena=%b exp 1", div_ena); else passed++;
        req_kill = 1'b1;
        @(posedge clk);
        #1;
        req_kill = 1'b0;
        total++; if (req_ready !== 1'b1 || div_ena !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL kill_run got ready=%b ena=%b valid=%b exp 1 0 0", req_ready, div_ena, rsp_valid);
        else passed++;
        start_op(1'b0, 32'd81, 32'd9, lat, ena, q, r, d0, ov, z, d);
        total++; if (lat !== 34 || ena !== 33) $display("FAIL kill_next_latency got %0d/%0d exp 34/33", lat, ena); else passed++;
        total++; if (q !== 32'd9 || r !== 32'd0) $display("FAIL kill_next_result got %0d %0d exp 9 0", q, r); else passed++;
        // Kill in DONE with rsp_ready high: no delivery, and nothing reappears
        start_op(1'b0, 32'd50, 32'd5, lat, ena, q, r, d0, ov, z, d);
        req_kill  = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_kill  = 1'b0;
        rsp_ready = 1'b0;
        seen = 0;
        repeat (5) begin
            if (rsp_valid) seen++;
            @(posedge clk);
            #1;
        end
        total++; if (seen !== 0 || req_ready !== 1'b1)
            $display("FAIL kill_done got valid_cycles=%0d ready=%b exp 0 1", seen, req_ready);
        else passed++;
    endtask

    task automatic test_rst_mid_run();
        int lat, ena;
        logic [DW-1:0] q, r, d;
        logic [2*DW-1:0] z;
        logic d0, ov;
        req_valid  = 1'b1;
        req_signed = 1'b1;
        req_a = 32'hFFFFFF00;
        req_b = 32'd7;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst = 1'b1;
        #1;
        total++; if (div_ena !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rst_mid_run_ctrl got ena=%b ready=%b valid=%b exp 0 1 0", div_ena, req_ready, rsp_valid);
        else passed++;
        total++; if (div_z !== 64'h0 || div_d !== 32'h0 || rsp_q !== 32'h0 || rsp_r !== 32'h0)
            $display("FAIL rst_mid_run_data got %h %h %h %h exp 0", div_z, div_d, rsp_q, rsp_r);
        else passed++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_op(1'b0, 32'd81, 32'd9, lat, ena, q, r, d0, ov, z, d);
        total++; if (lat !== 34 || q !== 32'd9 || r !== 32'd0)
            $display("FAIL rst_recover got lat=%0d q=%0d r=%0d exp 34 9 0", lat, q, r);
        else passed++;
        finish_op();
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_kill   = 1'b0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_normal();
        test_div0();
        test_ovf();
        test_hold();
        test_kill_idle();
        test_kill();
        test_rst_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
